// File: rtl/seg7_pkg.sv
// Shared constants, committed-display record and hex segment table for the 7-segment scan block.
// All segment encodings are active-low with g..a in [6:0] and the decimal point in [7].
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int unsigned DP_BIT = 7;
    localparam logic [3:0] DIG_NONE = 4'hF;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lzb;
        logic [3:0]  bright;
    } disp_cfg_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] code;
        code = SEG_BLANK;
        unique case (nib)
            4'h0: code = 8'hC0;
            4'h1: code = 8'hF9;
            4'h2: code = 8'hA4;
            4'h3: code = 8'hB0;
            4'h4: code = 8'h99;
            4'h5: code = 8'h92;
            4'h6: code = 8'h82;
            4'h7: code = 8'hF8;
            4'h8: code = 8'h80;
            4'h9: code = 8'h90;
            4'hA: code = 8'h88;
            4'hB: code = 8'h83;
            4'hC: code = 8'hC6;
            4'hD: code = 8'hA1;
            4'hE: code = 8'h86;
            4'hF: code = 8'h8E;
            default: code = SEG_BLANK;
        endcase
        return code[6:0];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low g..a segment pattern; the decimal point is handled by the caller.
module seg7_hex_decode (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    import seg7_pkg::*;

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode 7-segment scanner with dead time, PWM brightness, leading-zero
// blanking and a load/ack handshake that only swaps display contents on frame boundaries.
module seg7_scan_ctrl #(
    parameter int unsigned SLOT_W      = 16,
    parameter int unsigned DEAD_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        lzb,
    input  logic [3:0]  bright,
    output logic        load_ack,
    output logic        busy,
    output logic        frame_start,
    output logic [3:0]  dig,
    output logic [7:0]  seg
);
    import seg7_pkg::*;

    localparam logic [SLOT_W-1:0] DEAD = SLOT_W'(DEAD_CYCLES);

    logic [SLOT_W-1:0] cnt_q;
    logic [1:0]        idx_q;
    disp_cfg_t         pend_q;
    disp_cfg_t         cur_q;
    logic              busy_q;
    logic              ack_q;
    logic              fs_q;
    logic [3:0]        dig_q;
    logic [7:0]        seg_q;

    logic              cnt_max;
    logic              frame_end;
    logic              commit;
    logic [3:0]        nib;
    logic [6:0]        hex_seg;
    logic [3:0]        blank;
    logic              lit;
    logic [3:0]        dig_d;
    logic [7:0]        seg_d;

    assign cnt_max   = &cnt_q;
    assign frame_end = (idx_q == 2'd3) && cnt_max;
    // Commit takes the data that was pending before this edge; a load in the same
    // cycle lands in pending and waits for the next frame end.
    assign commit    = frame_end && busy_q;

    always_comb begin
        nib = 4'h0;
        unique case (idx_q)
            2'd0: nib = cur_q.value[3:0];
            2'd1: nib = cur_q.value[7:4];
            2'd2: nib = cur_q.value[11:8];
            2'd3: nib = cur_q.value[15:12];
            default: nib = 4'h0;
        endcase
    end

    seg7_hex_decode u_hex_decode (
        .nibble (nib),
        .seg    (hex_seg)
    );

    // Blanking ripples down from the most significant digit; digit0 always shows.
    always_comb begin
        blank    = 4'b0000;
        blank[3] = cur_q.lzb && (cur_q.value[15:12] == 4'h0);
        blank[2] = blank[3] && (cur_q.value[11:8] == 4'h0);
        blank[1] = blank[2] && (cur_q.value[7:4] == 4'h0);
        blank[0] = 1'b0;
    end

    always_comb begin
        lit   = (cnt_q >= DEAD) && (cnt_q[SLOT_W-1 -: 4] < cur_q.bright) && !blank[idx_q];
        dig_d = DIG_NONE;
        seg_d = SEG_BLANK;
        if (lit) begin
            dig_d         = ~(4'b0001 << idx_q);
            seg_d[6:0]    = hex_seg;
            seg_d[DP_BIT] = ~cur_q.dp[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            pend_q <= '0;
            cur_q  <= '0;
            busy_q <= 1'b0;
            ack_q  <= 1'b0;
            fs_q   <= 1'b0;
            dig_q  <= DIG_NONE;
            seg_q  <= SEG_BLANK;
        end else begin
            cnt_q <= cnt_q + SLOT_W'(1);
            if (cnt_max) begin
                idx_q <= idx_q + 2'd1;
            end
            if (load) begin
                pend_q <= disp_cfg_t'{value: value, dp: dp, lzb: lzb, bright: bright};
            end
            if (commit) begin
                cur_q <= pend_q;
            end
            if (load) begin
                busy_q <= 1'b1;
            end else if (commit) begin
                busy_q <= 1'b0;
            end
            ack_q <= commit;
            fs_q  <= (idx_q == 2'd0) && (cnt_q == '0);
            dig_q <= dig_d;
            seg_q <= seg_d;
        end
    end

    assign load_ack    = ack_q;
    assign busy        = busy_q;
    assign frame_start = fs_q;
    assign dig         = dig_q;
    assign seg         = seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with a 64-cycle slot and 4-cycle dead time.
module tb_seg7_scan_ctrl;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lzb;
        logic [3:0]  bright;
        logic [31:0] segs;   // {digit3, digit2, digit1, digit0}; FF = digit dark
    } vec_t;

    typedef struct {
        logic       fs;
        logic [3:0] dig;
        logic [7:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic        lzb = 1'b0;
    logic [3:0]  bright = '0;
    logic        load_ack, busy, frame_start;
    logic [3:0]  dig;
    logic [7:0]  seg;

    int   total = 0;
    int   bad = 0;
    int   pos = 0;   // frame position (idx*64 + cnt) expected in the DUT counters
    exp_t sb[$];
    vec_t vecs[11];
    vec_t dark_v;
    vec_t v;

    seg7_scan_ctrl #(
        .SLOT_W      (6),
        .DEAD_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value       (value),
        .dp          (dp),
        .lzb         (lzb),
        .bright      (bright),
        .load_ack    (load_ack),
        .busy        (busy),
        .frame_start (frame_start),
        .dig         (dig),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) pos <= 0;
        else     pos <= (pos + 1) % 256;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (pos %0d)", name, act, exp, pos);
        end
    endtask

    task automatic do_load(input vec_t lv);
        value  = lv.value;
        dp     = lv.dp;
        lzb    = lv.lzb;
        bright = lv.bright;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (load_ack !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ack"}, {31'd0, load_ack}, 32'd1);
        check({name, "_ack_pos"}, pos, 32'd0);
    endtask

    // Runs one full frame from the current position, queueing the expected output for
    // each counter state and comparing after the output register has taken it.
    task automatic check_frame(input vec_t fv, input string name);
        exp_t e;
        exp_t got;
        int   c;
        int   d;
        logic [7:0] s;
        for (int k = 0; k < 256; k++) begin
            c = pos % 64;
            d = pos / 64;
            s = fv.segs[8*d +: 8];
            e.fs = (pos == 0);
            if (c >= 4 && c < 4 * int'(fv.bright) && s != 8'hFF) begin
                e.dig = ~(4'b0001 << d);
                e.seg = s;
            end else begin
                e.dig = 4'hF;
                e.seg = 8'hFF;
            end
            sb.push_back(e);
            @(posedge clk);
            @(negedge clk);
            got = sb.pop_front();
            check({name, "_out"}, {19'd0, frame_start, dig, seg}, {19'd0, got.fs, got.dig, got.seg});
            check({name, "_idle"}, {30'd0, load_ack, busy}, 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{16'h12AF, 4'b0100, 1'b0, 4'd15, 32'hF924888E};
        vecs[1]  = '{16'h12AF, 4'b0100, 1'b0, 4'd4,  32'hF924888E};
        vecs[2]  = '{16'h12AF, 4'b0100, 1'b0, 4'd0,  32'hF924888E};
        vecs[3]  = '{16'h0070, 4'b0100, 1'b1, 4'd15, 32'hFFFFF8C0};
        vecs[4]  = '{16'h0000, 4'b0000, 1'b1, 4'd15, 32'hFFFFFFC0};
        vecs[5]  = '{16'h0000, 4'b1111, 1'b1, 4'd15, 32'hFFFFFF40};
        vecs[6]  = '{16'h8421, 4'b1000, 1'b1, 4'd9,  32'h0099A4F9};
        vecs[7]  = '{16'h0B0C, 4'b0010, 1'b1, 4'd15, 32'hFF8340C6};
        vecs[8]  = '{16'hEF6D, 4'b0000, 1'b1, 4'd2,  32'h868E82A1};
        vecs[9]  = '{16'h3579, 4'b0001, 1'b0, 4'd15, 32'hB092F810};
        vecs[10] = '{16'h0070, 4'b0000, 1'b0, 4'd15, 32'hC0C0F8C0};
        dark_v   = '{16'h0000, 4'b0000, 1'b0, 4'd0,  32'hFFFFFFFF};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dig", {28'd0, dig}, 32'hF);
        check("rst_seg", {24'd0, seg}, 32'hFF);
        check("rst_ack", {31'd0, load_ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fs", {31'd0, frame_start}, 32'd0);
        rst = 1'b0;
        check_frame(dark_v, "post_rst_dark");

        // Table of display contents
        for (int i = 0; i < 11; i++) begin
            repeat (20 + 7 * i) @(negedge clk);
            do_load(vecs[i]);
            check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            wait_ack($sformatf("v%0d", i));
            check($sformatf("v%0d_busy_clr", i), {31'd0, busy}, 32'd0);
            check_frame(vecs[i], $sformatf("v%0d", i));
        end

        // Several loads in one frame: one ack, last value wins
        repeat (10) @(negedge clk);
        v = '{16'h1111, 4'b0000, 1'b0, 4'd15, 32'hF9F9F9F9};
        do_load(v);
        repeat (40) @(negedge clk);
        v = '{16'h2222, 4'b0000, 1'b0, 4'd15, 32'hA4A4A4A4};
        do_load(v);
        repeat (40) @(negedge clk);
        v = '{16'h3333, 4'b0000, 1'b0, 4'd15, 32'hB0B0B0B0};
        do_load(v);
        check("multi_busy", {31'd0, busy}, 32'd1);
        wait_ack("multi");
        check_frame(v, "multi");

        // Load exactly in the frame-end cycle with nothing pending
        while (pos != 255) @(negedge clk);
        v = '{16'h4C0D, 4'b0000, 1'b0, 4'd15, 32'h99C6C0A1};
        do_load(v);
        check("fe_no_ack", {30'd0, load_ack, busy}, 32'd1);
        for (int k = 0; k < 255; k++) begin
            @(negedge clk);
            check("fe_busy_hold", {30'd0, load_ack, busy}, 32'd1);
        end
        @(negedge clk);
        check("fe_commit", {30'd0, load_ack, busy}, 32'd2);
        check_frame(v, "fe");

        // Load held across a commit edge keeps busy and earns a second ack
        while (pos != 250) @(negedge clk);
        v = vecs[0];
        value = v.value; dp = v.dp; lzb = v.lzb; bright = v.bright;
        load = 1'b1;
        while (pos != 0) @(negedge clk);
        check("held_commit", {30'd0, load_ack, busy}, 32'd3);
        @(negedge clk);
        @(negedge clk);
        load = 1'b0;
        check("held_busy", {30'd0, load_ack, busy}, 32'd1);
        wait_ack("held");
        check_frame(v, "held");

        // Reset in the middle of the digit2 slot discards pending data
        while (pos != 148) @(negedge clk);
        check("mid_dig2", {20'd0, dig, seg}, {20'd0, 4'hB, 8'h24});
        v = '{16'h5555, 4'b0000, 1'b0, 4'd15, 32'h92929292};
        do_load(v);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_out", {20'd0, dig, seg}, {20'd0, 4'hF, 8'hFF});
        check("mrst_flags", {29'd0, load_ack, busy, frame_start}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_fs", {31'd0, frame_start}, 32'd1);
        check_frame(dark_v, "mrst_dark");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
